// File: rtl/hintarb_pkg.sv
// Shared constants for the hypervisor interrupt arbiter:
// privilege encodings, interrupt bit indices, targets and FSM states.
package hintarb_pkg;

    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    localparam int SSI  = 1;
    localparam int VSSI = 2;
    localparam int MSI  = 3;
    localparam int STI  = 5;
    localparam int VSTI = 6;
    localparam int MTI  = 7;
    localparam int SEI  = 9;
    localparam int VSEI = 10;
    localparam int MEI  = 11;
    localparam int SGEI = 12;

    localparam logic [1:0] INTTGT_M  = 2'b11;
    localparam logic [1:0] INTTGT_HS = 2'b01;
    localparam logic [1:0] INTTGT_VS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

endpackage

// File: rtl/hintarb_intprio.sv
// Fixed-priority picker over a 13-bit interrupt candidate vector.
// Order: 11, 3, 7, 9, 1, 5, 12, 10, 2, 6.
module hintarb_intprio
    import hintarb_pkg::*;
(
    input  logic [12:0] cand_i,
    output logic        valid_o,
    output logic [3:0]  idx_o
);

    always_comb begin
        valid_o = 1'b1;
        idx_o   = 4'd0;
        priority case (1'b1)
            cand_i[MEI]:  idx_o = 4'(MEI);
            cand_i[MSI]:  idx_o = 4'(MSI);
            cand_i[MTI]:  idx_o = 4'(MTI);
            cand_i[SEI]:  idx_o = 4'(SEI);
            cand_i[SSI]:  idx_o = 4'(SSI);
            cand_i[STI]:  idx_o = 4'(STI);
            cand_i[SGEI]: idx_o = 4'(SGEI);
            cand_i[VSEI]: idx_o = 4'(VSEI);
            cand_i[VSSI]: idx_o = 4'(VSSI);
            cand_i[VSTI]: idx_o = 4'(VSTI);
            default:      valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear on reset.
module synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/hintarb.sv
// Hypervisor interrupt arbiter: merges M/HS/VS pending interrupts
// and presents one registered request under a req/ack handshake.
module hintarb
    import hintarb_pkg::*;
#(
    parameter int GEILEN = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GEILEN-1:0] GuestExtIntIn,
    input  logic [12:0]       MIP_REGW,
    input  logic [12:0]       MIE_REGW,
    input  logic [12:0]       MIDELEG_REGW,
    input  logic [12:0]       HIDELEG_REGW,
    input  logic [12:0]       HVIP_REGW,
    input  logic [GEILEN-1:0] HGEIE_REGW,
    input  logic [5:0]        VGEIN,
    input  logic [1:0]        PrivilegeModeW,
    input  logic              VirtModeW,
    input  logic              MStatusMIE,
    input  logic              SStatusSIE,
    input  logic              VSStatusSIE,
    input  logic              StallM,
    input  logic              IntAckM,
    output logic              IntReqM,
    output logic [5:0]        IntCauseM,
    output logic [1:0]        IntTargetM,
    output logic [GEILEN-1:0] HGEIP_REGW,
    output logic              WakeM
);

    state_e      state_q, state_d;
    logic [5:0]  cause_q, cause_d;
    logic [1:0]  tgt_q, tgt_d;
    logic        wake_q;

    for (genvar i = 0; i < GEILEN; i++) begin : g_sync
        synchronizer u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (GuestExtIntIn[i]),
            .q     (HGEIP_REGW[i])
        );
    end

    logic [63:0] hgeip_ext;
    logic [5:0]  vgein_idx;
    logic        vgein_ok;
    logic        sgeip, vseip;

    assign hgeip_ext = 64'(HGEIP_REGW);
    assign vgein_idx = VGEIN - 6'd1;
    assign vgein_ok  = (VGEIN != 6'd0) && (VGEIN <= 6'(GEILEN));
    assign sgeip     = |(HGEIP_REGW & HGEIE_REGW);
    assign vseip     = HVIP_REGW[VSEI] | (vgein_ok & hgeip_ext[vgein_idx]);

    logic [12:0] pend, en;
    assign pend = MIP_REGW | {sgeip, 1'b0, vseip, 3'b0,
                              HVIP_REGW[VSTI], 3'b0,
                              HVIP_REGW[VSSI], 2'b0};
    assign en = pend & MIE_REGW;

    logic unused_hvip;
    assign unused_hvip = ^{HVIP_REGW[12:11], HVIP_REGW[9:7],
                           HVIP_REGW[5:3], HVIP_REGW[1:0]};

    logic in_m, in_s, in_u;
    logic m_en, hs_en, vs_en;
    assign in_m  = PrivilegeModeW == M_MODE;
    assign in_s  = PrivilegeModeW == S_MODE;
    assign in_u  = PrivilegeModeW == U_MODE;
    assign m_en  = !in_m || MStatusMIE;
    assign hs_en = !in_m && (VirtModeW || in_u || (in_s && SStatusSIE));
    assign vs_en = VirtModeW && (in_u || VSStatusSIE);

    // VS level only ever sees the three virtual-supervisor bits
    localparam logic [12:0] VS_MASK = 13'h0444;

    logic [12:0] m_cand, hs_cand, vs_cand;
    assign m_cand  = en & ~MIDELEG_REGW & {13{m_en}};
    assign hs_cand = en & MIDELEG_REGW & ~HIDELEG_REGW & {13{hs_en}};
    assign vs_cand = en & MIDELEG_REGW & HIDELEG_REGW & VS_MASK
                     & {13{vs_en}};

    logic       m_v, hs_v, vs_v;
    logic [3:0] m_idx, hs_idx, vs_idx;

    hintarb_intprio u_prio_m (
        .cand_i  (m_cand),
        .valid_o (m_v),
        .idx_o   (m_idx)
    );

    hintarb_intprio u_prio_hs (
        .cand_i  (hs_cand),
        .valid_o (hs_v),
        .idx_o   (hs_idx)
    );

    hintarb_intprio u_prio_vs (
        .cand_i  (vs_cand),
        .valid_o (vs_v),
        .idx_o   (vs_idx)
    );

    logic       win;
    logic [5:0] win_cause;
    logic [1:0] win_tgt;

    always_comb begin
        win       = 1'b1;
        win_cause = 6'd0;
        win_tgt   = 2'b00;
        if (m_v) begin
            win_cause = {2'b0, m_idx};
            win_tgt   = INTTGT_M;
        end else if (hs_v) begin
            win_cause = {2'b0, hs_idx};
            win_tgt   = INTTGT_HS;
        end else if (vs_v) begin
            win_cause = {2'b0, vs_idx - 4'd1};
            win_tgt   = INTTGT_VS;
        end else begin
            win = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= 6'd0;
            tgt_q   <= 2'b00;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tgt_q   <= tgt_d;
            wake_q  <= |en;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (IntAckM)     state_d = ST_BLANK;
                else if (StallM) state_d = ST_REQ;
                else if (!win)   state_d = ST_IDLE;
            end
            ST_BLANK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    logic capture;
    always_comb begin
        capture = 1'b0;
        cause_d = cause_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            ST_IDLE: capture = win;
            ST_REQ:  capture = win && !IntAckM && !StallM;
            default: capture = 1'b0;
        endcase
        if (capture) begin
            cause_d = win_cause;
            tgt_d   = win_tgt;
        end
    end

    assign IntReqM    = state_q == ST_REQ;
    assign IntCauseM  = cause_q;
    assign IntTargetM = tgt_q;
    assign WakeM      = wake_q;

endmodule
